alu_rs: RTL and testbench

- Reservation station feeding the common integer ALU in the out-of-order core.
- Buffers issued arithmetic/logic ops until both source operands are available, snooping the ALU and LSB result buses (CDB) for outstanding ROB tags.
- Each cycle, dispatches at most one ready entry to the ALU as a registered one-cycle `alu_new` pulse with operands, op fields and ROB entry.
- Cleared entirely on pipeline flush (branch mispredict).

---
 rtl/alu_rs.sv | 205 ++++++++++++++++++++
 tb/tb_alu_rs.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU: holds ops until both operands
// are known, snoops the ALU/LSB result buses, and dispatches one ready entry per cycle.
module alu_rs #(
    parameter int RS_SIZE_BIT  = 3,
    parameter int ROB_SIZE_BIT = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,

    input  logic                    issue_valid,
    input  logic [2:0]              issue_op,
    input  logic                    issue_op_addition,
    input  logic                    issue_has_imm,
    input  logic [31:0]             issue_imm,
    input  logic [31:0]             issue_vi,
    input  logic                    issue_qi_busy,
    input  logic [ROB_SIZE_BIT-1:0] issue_qi,
    input  logic [31:0]             issue_vj,
    input  logic                    issue_qj_busy,
    input  logic [ROB_SIZE_BIT-1:0] issue_qj,
    input  logic [ROB_SIZE_BIT-1:0] issue_rob_entry,
    output logic                    rs_full,

    input  logic                    cdb_alu_valid,
    input  logic [ROB_SIZE_BIT-1:0] cdb_alu_rob_entry,
    input  logic [31:0]             cdb_alu_value,
    input  logic                    cdb_lsb_valid,
    input  logic [ROB_SIZE_BIT-1:0] cdb_lsb_rob_entry,
    input  logic [31:0]             cdb_lsb_value,

    output logic                    alu_new,
    output logic [31:0]             alu_vi,
    output logic [31:0]             alu_vj,
    output logic [31:0]             alu_imm,
    output logic [2:0]              alu_op,
    output logic                    alu_has_imm,
    output logic                    alu_op_addition,
    output logic [ROB_SIZE_BIT-1:0] alu_rob_entry
);

    localparam int RS_SIZE = 1 << RS_SIZE_BIT;

    typedef struct packed {
        logic                    valid;
        logic [2:0]              op;
        logic                    op_addition;
        logic                    has_imm;
        logic [31:0]             imm;
        logic [31:0]             vi;
        logic                    qi_busy;
        logic [ROB_SIZE_BIT-1:0] qi;
        logic [31:0]             vj;
        logic                    qj_busy;
        logic [ROB_SIZE_BIT-1:0] qj;
        logic [ROB_SIZE_BIT-1:0] rob_entry;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];

    logic                    alu_new_q, alu_new_d;
    logic [31:0]             alu_vi_q, alu_vi_d;
    logic [31:0]             alu_vj_q, alu_vj_d;
    logic [31:0]             alu_imm_q, alu_imm_d;
    logic [2:0]              alu_op_q, alu_op_d;
    logic                    alu_has_imm_q, alu_has_imm_d;
    logic                    alu_op_addition_q, alu_op_addition_d;
    logic [ROB_SIZE_BIT-1:0] alu_rob_entry_q, alu_rob_entry_d;

    logic [RS_SIZE-1:0]     valid_vec;
    logic [RS_SIZE-1:0]     ready_vec;
    logic [RS_SIZE_BIT-1:0] free_idx;
    logic [RS_SIZE_BIT-1:0] cand_idx;

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_status
            assign valid_vec[gi] = ent_q[gi].valid;
            assign ready_vec[gi] = ent_q[gi].valid && !ent_q[gi].qi_busy && !ent_q[gi].qj_busy;
        end
    endgenerate

    assign rs_full = &valid_vec;

    // Returns {busy, value} after looking at both result buses; the ALU bus wins a tie.
    function automatic logic [32:0] snoop(input logic busy, input logic [ROB_SIZE_BIT-1:0] tag,
                                          input logic [31:0] value);
        logic [32:0] res;
        res = {busy, value};
        if (busy) begin
            if (cdb_alu_valid && cdb_alu_rob_entry == tag) begin
                res = {1'b0, cdb_alu_value};
            end else if (cdb_lsb_valid && cdb_lsb_rob_entry == tag) begin
                res = {1'b0, cdb_lsb_value};
            end
        end
        return res;
    endfunction

    always_comb begin
        free_idx = '0;
        cand_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_vec[i]) free_idx = RS_SIZE_BIT'(i);
            if (ready_vec[i])  cand_idx = RS_SIZE_BIT'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
        end
        alu_new_d         = 1'b0;
        alu_vi_d          = alu_vi_q;
        alu_vj_d          = alu_vj_q;
        alu_imm_d         = alu_imm_q;
        alu_op_d          = alu_op_q;
        alu_has_imm_d     = alu_has_imm_q;
        alu_op_addition_d = alu_op_addition_q;
        alu_rob_entry_d   = alu_rob_entry_q;

        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i].valid = 1'b0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].valid) begin
                    {ent_d[i].qi_busy, ent_d[i].vi} = snoop(ent_q[i].qi_busy, ent_q[i].qi, ent_q[i].vi);
                    {ent_d[i].qj_busy, ent_d[i].vj} = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
                end
            end

            // Selection looks at registered state only, so fresh wakeups wait a cycle.
            if (|ready_vec) begin
                alu_new_d         = 1'b1;
                alu_vi_d          = ent_q[cand_idx].vi;
                alu_vj_d          = ent_q[cand_idx].vj;
                alu_imm_d         = ent_q[cand_idx].imm;
                alu_op_d          = ent_q[cand_idx].op;
                alu_has_imm_d     = ent_q[cand_idx].has_imm;
                alu_op_addition_d = ent_q[cand_idx].op_addition;
                alu_rob_entry_d   = ent_q[cand_idx].rob_entry;
                ent_d[cand_idx].valid = 1'b0;
            end

            if (issue_valid && !rs_full) begin
                ent_d[free_idx].valid       = 1'b1;
                ent_d[free_idx].op          = issue_op;
                ent_d[free_idx].op_addition = issue_op_addition;
                ent_d[free_idx].has_imm     = issue_has_imm;
                ent_d[free_idx].imm         = issue_imm;
                ent_d[free_idx].qi          = issue_qi;
                ent_d[free_idx].qj          = issue_qj;
                ent_d[free_idx].rob_entry   = issue_rob_entry;
                {ent_d[free_idx].qi_busy, ent_d[free_idx].vi} = snoop(issue_qi_busy, issue_qi, issue_vi);
                if (issue_has_imm) begin
                    {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = {1'b0, issue_vj};
                end else begin
                    {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = snoop(issue_qj_busy, issue_qj, issue_vj);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            alu_new_q         <= 1'b0;
            alu_vi_q          <= '0;
            alu_vj_q          <= '0;
            alu_imm_q         <= '0;
            alu_op_q          <= '0;
            alu_has_imm_q     <= 1'b0;
            alu_op_addition_q <= 1'b0;
            alu_rob_entry_q   <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
            alu_new_q         <= alu_new_d;
            alu_vi_q          <= alu_vi_d;
            alu_vj_q          <= alu_vj_d;
            alu_imm_q         <= alu_imm_d;
            alu_op_q          <= alu_op_d;
            alu_has_imm_q     <= alu_has_imm_d;
            alu_op_addition_q <= alu_op_addition_d;
            alu_rob_entry_q   <= alu_rob_entry_d;
        end
    end

    assign alu_new         = alu_new_q;
    assign alu_vi          = alu_vi_q;
    assign alu_vj          = alu_vj_q;
    assign alu_imm         = alu_imm_q;
    assign alu_op          = alu_op_q;
    assign alu_has_imm     = alu_has_imm_q;
    assign alu_op_addition = alu_op_addition_q;
    assign alu_rob_entry   = alu_rob_entry_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, all checked each cycle
// against a behavioural model of the station kept here.
module tb_alu_rs;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        issue_valid, issue_op_addition, issue_has_imm, issue_qi_busy, issue_qj_busy;
    logic [2:0]  issue_op;
    logic [31:0] issue_imm, issue_vi, issue_vj;
    logic [3:0]  issue_qi, issue_qj, issue_rob_entry;
    logic        rs_full;
    logic        cdb_alu_valid, cdb_lsb_valid;
    logic [3:0]  cdb_alu_rob_entry, cdb_lsb_rob_entry;
    logic [31:0] cdb_alu_value, cdb_lsb_value;
    logic        alu_new, alu_has_imm, alu_op_addition;
    logic [31:0] alu_vi, alu_vj, alu_imm;
    logic [2:0]  alu_op;
    logic [3:0]  alu_rob_entry;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_in = ~clk_in;

    alu_rs #(.RS_SIZE_BIT(3), .ROB_SIZE_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_op_addition(issue_op_addition),
        .issue_has_imm(issue_has_imm), .issue_imm(issue_imm), .issue_vi(issue_vi),
        .issue_qi_busy(issue_qi_busy), .issue_qi(issue_qi), .issue_vj(issue_vj),
        .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj), .issue_rob_entry(issue_rob_entry),
        .rs_full(rs_full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_entry(cdb_alu_rob_entry), .cdb_alu_value(cdb_alu_value),
        .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_entry(cdb_lsb_rob_entry), .cdb_lsb_value(cdb_lsb_value),
        .alu_new(alu_new), .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_imm(alu_imm), .alu_op(alu_op),
        .alu_has_imm(alu_has_imm), .alu_op_addition(alu_op_addition), .alu_rob_entry(alu_rob_entry)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [2:0]  op;
        bit          add, hi;
        logic [31:0] imm, vi, vj;
        bit          qib, qjb;
        logic [3:0]  qi, qj, rob;
    } ment_t;

    ment_t       m [8];
    logic        m_new, m_hi, m_add;
    logic [31:0] m_vi, m_vj, m_imm;
    logic [2:0]  m_op;
    logic [3:0]  m_rob;

    function automatic bit m_full();
        for (int i = 0; i < 8; i++) if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_wake(inout bit busy, input logic [3:0] tag, inout logic [31:0] val);
        if (!busy) return;
        if (cdb_alu_valid && cdb_alu_rob_entry == tag) begin
            busy = 1'b0; val = cdb_alu_value;
        end else if (cdb_lsb_valid && cdb_lsb_rob_entry == tag) begin
            busy = 1'b0; val = cdb_lsb_value;
        end
    endfunction

    task automatic model_step();
        ment_t nm [8];
        int    cand, slot;
        if (rst_in) begin
            for (int i = 0; i < 8; i++) m[i].v = 1'b0;
            m_new = 0; m_vi = 0; m_vj = 0; m_imm = 0; m_op = 0; m_hi = 0; m_add = 0; m_rob = 0;
        end else if (!rdy_in) begin
            // stalled: nothing moves
        end else if (flush) begin
            for (int i = 0; i < 8; i++) m[i].v = 1'b0;
            m_new = 1'b0;
        end else begin
            nm = m;
            cand = -1;
            slot = -1;
            for (int i = 7; i >= 0; i--) begin
                if (m[i].v && !m[i].qib && !m[i].qjb) cand = i;
                if (!m[i].v) slot = i;
            end
            for (int i = 0; i < 8; i++) begin
                if (nm[i].v) begin
                    m_wake(nm[i].qib, nm[i].qi, nm[i].vi);
                    m_wake(nm[i].qjb, nm[i].qj, nm[i].vj);
                end
            end
            if (cand >= 0) begin
                m_new = 1'b1; m_vi = m[cand].vi; m_vj = m[cand].vj; m_imm = m[cand].imm;
                m_op = m[cand].op; m_hi = m[cand].hi; m_add = m[cand].add; m_rob = m[cand].rob;
                nm[cand].v = 1'b0;
            end else begin
                m_new = 1'b0;
            end
            if (issue_valid && slot >= 0) begin
                nm[slot].v   = 1'b1;          nm[slot].op  = issue_op;
                nm[slot].add = issue_op_addition; nm[slot].hi = issue_has_imm;
                nm[slot].imm = issue_imm;     nm[slot].rob = issue_rob_entry;
                nm[slot].qi  = issue_qi;      nm[slot].qj  = issue_qj;
                nm[slot].vi  = issue_vi;      nm[slot].qib = issue_qi_busy;
                nm[slot].vj  = issue_vj;      nm[slot].qjb = issue_qj_busy && !issue_has_imm;
                m_wake(nm[slot].qib, nm[slot].qi, nm[slot].vi);
                m_wake(nm[slot].qjb, nm[slot].qj, nm[slot].vj);
            end
            m = nm;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("alu_new", {31'b0, alu_new}, {31'b0, m_new});
        chk("rs_full", {31'b0, rs_full}, {31'b0, m_full()});
        chk("alu_vi", alu_vi, m_vi);
        chk("alu_vj", alu_vj, m_vj);
        chk("alu_imm", alu_imm, m_imm);
        chk("alu_op", {29'b0, alu_op}, {29'b0, m_op});
        chk("alu_has_imm", {31'b0, alu_has_imm}, {31'b0, m_hi});
        chk("alu_op_addition", {31'b0, alu_op_addition}, {31'b0, m_add});
        chk("alu_rob_entry", {28'b0, alu_rob_entry}, {28'b0, m_rob});
    endtask

    int cyc = 0;

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
        cyc++;
        compare_all();
        $display("cycle %0d: alu_new=%0b rob=%0h vi=%0h vj=%0h rs_full=%0b", cyc, alu_new,
                 alu_rob_entry, alu_vi, alu_vj, rs_full);
        issue_valid = 0; cdb_alu_valid = 0; cdb_lsb_valid = 0; flush = 0; rst_in = 0;
    endtask

    task automatic iss(input logic [2:0] op, input logic add, input logic hi, input logic [31:0] imm,
                       input logic [31:0] vi, input logic qib, input logic [3:0] qi,
                       input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                       input logic [3:0] rob);
        issue_valid = 1; issue_op = op; issue_op_addition = add; issue_has_imm = hi; issue_imm = imm;
        issue_vi = vi; issue_qi_busy = qib; issue_qi = qi;
        issue_vj = vj; issue_qj_busy = qjb; issue_qj = qj; issue_rob_entry = rob;
    endtask

    task automatic alu_bus(input logic [3:0] tag, input logic [31:0] val);
        cdb_alu_valid = 1; cdb_alu_rob_entry = tag; cdb_alu_value = val;
    endtask

    task automatic lsb_bus(input logic [3:0] tag, input logic [31:0] val);
        cdb_lsb_valid = 1; cdb_lsb_rob_entry = tag; cdb_lsb_value = val;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; flush = 0;
        issue_valid = 0; issue_op = 0; issue_op_addition = 0; issue_has_imm = 0; issue_imm = 0;
        issue_vi = 0; issue_qi_busy = 0; issue_qi = 0; issue_vj = 0; issue_qj_busy = 0; issue_qj = 0;
        issue_rob_entry = 0;
        cdb_alu_valid = 0; cdb_alu_rob_entry = 0; cdb_alu_value = 0;
        cdb_lsb_valid = 0; cdb_lsb_rob_entry = 0; cdb_lsb_value = 0;

        // Reset
        tick();
        rst_in = 1; tick();
        chk("reset_new", {31'b0, alu_new}, 32'd0);
        chk("reset_full", {31'b0, rs_full}, 32'd0);
        chk("reset_vi", alu_vi, 32'd0);

        // 1: ready issue, dispatch two cycles later
        iss(3'b000, 0, 0, 0, 5, 0, 0, 7, 0, 0, 4'd3); tick();
        chk("t1_no_early", {31'b0, alu_new}, 32'd0);
        tick();
        chk("t1_new", {31'b0, alu_new}, 32'd1);
        chk("t1_vi", alu_vi, 32'd5);
        chk("t1_vj", alu_vj, 32'd7);
        chk("t1_rob", {28'b0, alu_rob_entry}, 32'd3);
        tick();
        chk("t1_pulse_end", {31'b0, alu_new}, 32'd0);

        // 2: wakeup via ALU bus
        iss(3'b000, 1, 0, 0, 0, 1, 4'd6, 1, 0, 0, 4'd4); tick();
        tick();
        alu_bus(4'd6, 32'h10); tick();
        chk("t2_not_yet", {31'b0, alu_new}, 32'd0);
        tick();
        chk("t2_new", {31'b0, alu_new}, 32'd1);
        chk("t2_vi", alu_vi, 32'h10);
        chk("t2_sub", {31'b0, alu_op_addition}, 32'd1);
        tick();

        // 3: same-cycle bypass, then dual wakeup
        iss(3'b100, 0, 0, 0, 0, 1, 4'd2, 3, 0, 0, 4'd5); lsb_bus(4'd2, 32'hAB); tick();
        tick();
        chk("t3_bypass_new", {31'b0, alu_new}, 32'd1);
        chk("t3_bypass_vi", alu_vi, 32'hAB);
        iss(3'b111, 0, 0, 0, 0, 1, 4'd5, 0, 1, 4'd7, 4'd1); tick();
        alu_bus(4'd5, 32'h55); lsb_bus(4'd7, 32'h77); tick();
        tick();
        chk("t3_dual_vi", alu_vi, 32'h55);
        chk("t3_dual_vj", alu_vj, 32'h77);
        tick();

        // 4: fill all 8 entries, refuse a 9th, drain in index order
        for (int i = 0; i < 8; i++) begin
            iss(3'b001, 0, 0, 0, 0, 1, 4'd9, 32'(i), 0, 0, 4'(i)); tick();
        end
        chk("t4_full", {31'b0, rs_full}, 32'd1);
        iss(3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd15); tick();
        chk("t4_still_full", {31'b0, rs_full}, 32'd1);
        alu_bus(4'd9, 32'h99); tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_drain_new", {31'b0, alu_new}, 32'd1);
            chk("t4_drain_rob", {28'b0, alu_rob_entry}, 32'(i));
            if (i == 0) chk("t4_full_falls", {31'b0, rs_full}, 32'd0);
        end
        tick();
        chk("t4_ninth_dropped", {31'b0, alu_new}, 32'd0);

        // 5: flush, then reset, with two woken entries and a concurrent issue
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                iss(3'b010, 0, 0, 0, 0, 1, (i < 2) ? 4'd12 : 4'd13, 0, 0, 0, 4'(i + 8)); tick();
            end
            alu_bus(4'd12, 32'h12); tick();
            iss(3'b011, 0, 0, 0, 1, 0, 0, 2, 0, 0, 4'd14);
            if (pass == 0) flush = 1; else rst_in = 1;
            tick();
            chk("t5_new", {31'b0, alu_new}, 32'd0);
            chk("t5_full", {31'b0, rs_full}, 32'd0);
            alu_bus(4'd13, 32'h13); tick();
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("t5_quiet", {31'b0, alu_new}, 32'd0);
            end
        end

        // 6: stall with a held dispatch pulse and bus traffic
        iss(3'b000, 0, 0, 0, 0, 1, 4'd3, 0, 0, 0, 4'd7); tick();
        iss(3'b000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4'd8); tick();
        iss(3'b000, 0, 0, 0, 2, 0, 0, 2, 0, 0, 4'd9); tick();
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            alu_bus(4'd3, 32'h33);
            iss(3'b000, 0, 0, 0, 9, 0, 0, 9, 0, 0, 4'd10);
            tick();
            chk("t6_hold_new", {31'b0, alu_new}, 32'd1);
            chk("t6_hold_rob", {28'b0, alu_rob_entry}, 32'd8);
        end
        rdy_in = 1; tick();
        chk("t6_resume_rob", {28'b0, alu_rob_entry}, 32'd9);
        tick();
        chk("t6_no_capture", {31'b0, alu_new}, 32'd0);
        alu_bus(4'd3, 32'h44); tick();
        tick();
        chk("t6_late_vi", alu_vi, 32'h44);
        chk("t6_late_rob", {28'b0, alu_rob_entry}, 32'd7);
        flush = 1; tick();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rdy_in = ($urandom_range(0, 7) != 0);
            flush  = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) begin
                iss(3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                    1'($urandom), 4'($urandom_range(0, 5)), $urandom,
                    1'($urandom), 4'($urandom_range(0, 5)), 4'($urandom));
            end
            if ($urandom_range(0, 2) == 0) alu_bus(4'($urandom_range(0, 5)), $urandom);
            if ($urandom_range(0, 2) == 0) lsb_bus(4'($urandom_range(0, 5)), $urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
